// File: rtl/sdpram_fifo_ctrl_pkg.sv
// Shared sizing helpers and types for the SDPRAM-backed FWFT FIFO controller.
// No logic: depth and count-width derivations plus the output-buffer count type.
package sdpram_fifo_ctrl_pkg;

  localparam int OB_DEPTH = 2;

  typedef logic [1:0] ob_cnt_t;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sdpram_fifo_ob2.sv
// 2-entry output skid buffer: captures RAM read data, head is visible the cycle after capture.
// Never refuses a capture; the parent only issues reads when a slot is guaranteed free.
module sdpram_fifo_ob2
  import sdpram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  cap_vld,
  input  logic [DATA_WIDTH-1:0] cap_dat,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output ob_cnt_t               ob_cnt
);

  logic [DATA_WIDTH-1:0] ent0;
  logic [DATA_WIDTH-1:0] ent1;
  logic                  pop_ok;

  assign pop_ok = pop && (ob_cnt != 2'd0);
  assign head   = ent0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0   <= '0;
      ent1   <= '0;
      ob_cnt <= '0;
    end else if (clear) begin
      ob_cnt <= '0;
    end else if (pop_ok && cap_vld) begin
      // Count is unchanged; at one entry the captured word replaces the head directly.
      if (ob_cnt == 2'd2) begin
        ent0 <= ent1;
        ent1 <= cap_dat;
      end else begin
        ent0 <= cap_dat;
      end
    end else if (cap_vld) begin
      if (ob_cnt == 2'd0) ent0 <= cap_dat;
      else                ent1 <= cap_dat;
      ob_cnt <= ob_cnt + 2'd1;
    end else if (pop_ok) begin
      ent0   <= ent1;
      ob_cnt <= ob_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/sdpram_fifo_ctrl.sv
// FWFT FIFO controller around a 1-cycle-latency SDPRAM; first word valid 3 cycles after push.
// s_ready drops only when the RAM itself is full; full throughput of one word per clock.
module sdpram_fifo_ctrl
  import sdpram_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH    = 11,
  parameter int DATA_WIDTH    = 9,
  parameter int AFULL_THRESH  = 2040,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  ram_rd_clk_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  ram_rst
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CW    = cnt_width(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [CW-1:0]         ram_cnt;
  logic [CW-1:0]         ram_cnt_next;
  logic [CW-1:0]         count_next;
  logic                  pend;
  logic                  full_r;
  ob_cnt_t               ob_cnt;
  ob_cnt_t               ob_cnt_next;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  capture;

  assign ram_rst = ~rst_n;
  assign s_ready = ~full_r;
  assign m_valid = (ob_cnt != 2'd0);

  assign push    = s_valid & s_ready & ~flush;
  assign pop     = m_valid & m_ready;
  assign capture = pend & ~flush;
  // Read ahead only if the word will have a buffer slot once it lands next cycle.
  assign issue   = ~flush & (ram_cnt != '0) &
                   ((3'(ob_cnt) + 3'(pend)) <= (3'd1 + 3'(pop)));

  assign ram_wr_en     = push;
  assign ram_wr_addr   = wptr;
  assign ram_wr_data   = s_data;
  assign ram_rd_clk_en = issue;
  assign ram_rd_addr   = rptr;

  assign count = ram_cnt + CW'(pend) + CW'(ob_cnt);

  always_comb begin
    ram_cnt_next = ram_cnt + CW'(push) - CW'(issue);
    ob_cnt_next  = ob_cnt + ob_cnt_t'(capture) - ob_cnt_t'(pop);
    if (flush) begin
      ram_cnt_next = '0;
      ob_cnt_next  = '0;
    end
    count_next = ram_cnt_next + CW'(issue) + CW'(ob_cnt_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      ram_cnt      <= '0;
      pend         <= 1'b0;
      full_r       <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push)  wptr <= wptr + ADDR_WIDTH'(1);
        if (issue) rptr <= rptr + ADDR_WIDTH'(1);
      end
      ram_cnt      <= ram_cnt_next;
      pend         <= issue;
      full_r       <= (ram_cnt_next == CW'(DEPTH));
      almost_full  <= (ram_cnt_next >= CW'(AFULL_THRESH));
      almost_empty <= (count_next <= CW'(AEMPTY_THRESH));
    end
  end

  sdpram_fifo_ob2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ob (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (flush),
    .cap_vld (capture),
    .cap_dat (ram_rd_data),
    .pop     (pop),
    .head    (m_data),
    .ob_cnt  (ob_cnt)
  );

endmodule

// File: doc/sdpram_fifo_ctrl.md
# sdpram_fifo_ctrl

Single-clock first-word-fall-through FIFO controller wrapped around the 2048×9 simple dual-port RAM (PGL_SDPRAM_11 configuration: 1-cycle read latency, no output register, read clock enable, async active-high reset).
- Owns write/read pointers and occupancy.
- Drives the RAM's write port and read address/clock-enable, consumes its read data.
- Presents valid/ready streams on both sides, hiding RAM latency with a 2-entry output buffer so throughput is one word per clock.

## Interface
Parameters:
- ADDR_WIDTH, 11, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 9, word width.
- AFULL_THRESH, 2040, almost_full asserts when ram_cnt >= this.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this.

Ports:
- clk  in  1  single clock; also drives RAM wr_clk and rd_clk.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all contents.
- s_valid  in  1  write request.
- s_ready  out  1  controller can accept a write this cycle.
- s_data  in  DATA_WIDTH  write data.
- m_valid  out  1  m_data holds the head word.
- m_ready  in  1  consumer takes the head word.
- m_data  out  DATA_WIDTH  head word.
- count  out  ADDR_WIDTH+1  total words held: ram_cnt + pend + ob_cnt.
- almost_full  out  1  registered, ram_cnt >= AFULL_THRESH.
- almost_empty  out  1  registered, count <= AEMPTY_THRESH.
- ram_wr_data  out  DATA_WIDTH  to RAM wr_data.
- ram_wr_addr  out  ADDR_WIDTH  to RAM wr_addr.
- ram_wr_en  out  1  to RAM wr_en.
- ram_rd_addr  out  ADDR_WIDTH  to RAM rd_addr.
- ram_rd_clk_en  out  1  to RAM rd_clk_en.
- ram_rd_data  in  DATA_WIDTH  from RAM rd_data.
- ram_rst  out  1  equals ~rst_n, drives RAM wr_rst and rd_rst.

## Operation
- Push: push = s_valid & s_ready.
  - Combinational outputs: ram_wr_en = push, ram_wr_addr = wptr, ram_wr_data = s_data.
  - wptr increments modulo DEPTH.
- s_ready = ~full_r.
  - full_r is registered: next value is (ram_cnt_next == DEPTH).
  - No same-cycle bypass when full.
- Issue: issue = (ram_cnt != 0) & (ob_cnt + pend - pop <= 1), where pop = m_valid & m_ready.
  - Combinational outputs: ram_rd_clk_en = issue, ram_rd_addr = rptr.
  - rptr increments modulo DEPTH.
  - pend_next = issue.
- Capture: when pend = 1, ram_rd_data is written into the output buffer tail this cycle.
- Output buffer:
  - Holds 0–2 words and behaves as a FIFO.
  - m_valid = (ob_cnt != 0); m_data = head.
  - Simultaneous capture and pop is legal, including at ob_cnt = 1 (head replaced by captured word).
- ram_cnt: next = ram_cnt + push − issue. Push and issue in the same cycle leave it unchanged.
- A word written at cycle t is readable at cycle t+1 at the earliest, since ram_cnt updates at end of t. No read-during-write hazard on the same address.
- flush:
  - Next edge: wptr, rptr, ram_cnt, pend, ob_cnt and full_r go to 0.
  - Push, issue and capture are ignored in the flush cycle.
  - An in-flight RAM read is discarded.
- Capacity: DEPTH + 2 = 2050 words. count never exceeds 2050.

## Timing
- Reset values (async, while rst_n = 0):
  - wptr = rptr = ram_cnt = pend = ob_cnt = 0.
  - m_data = 0, m_valid = 0, s_ready = 1, count = 0.
  - almost_full = 0, almost_empty = 1, ram_rst = 1.
- Empty-to-valid latency:
  - Push accepted at edge of cycle 0; issue in cycle 1; capture in cycle 2; m_valid = 1 in cycle 3.
- Steady state with s_valid = m_ready = 1: one word per cycle in and out, no bubbles.
- count, almost_full and almost_empty update one cycle after the event causing them.

## Structure
- Shared package/header: DEPTH and CNT_WIDTH (ADDR_WIDTH+1) derivations.
- One sub-module, sdpram_fifo_ob2: a 2-entry skid buffer with capture, pop, clear, head and ob_cnt.
- Pointers, ram_cnt, issue logic and flags stay in the top level.

## Test plan
- Reset, then one push of 0x1A5 with m_ready = 0 -> m_valid rises in cycle 3 with m_data = 0x1A5; count = 1.
- Stream 100 words 0..99 with s_valid = m_ready = 1 -> identical sequence out, one per cycle after 3-cycle fill.
- Push 2050 words with m_ready = 0:
  - s_ready drops after word 2048 enters RAM and the output buffer fills; count = 2050.
  - almost_full asserts at ram_cnt = 2040.
  - The 2051st s_valid is not accepted.
- From full, pop one word -> next word appears the following cycle; s_ready returns within 2 cycles. Continued streaming verifies wptr/rptr wrap past 2047 with data order intact.
- Assert flush with pend = 1 and ob_cnt = 2 -> next cycle m_valid = 0 and count = 0; a subsequent push of 0x055 emerges as m_data = 0x055, with no stale data.
- Drop rst_n mid-stream -> all outputs go to their reset values immediately and ram_rst = 1; after release, the FIFO operates from empty.
